// File: rtl/fetch_stage_if.sv
// Instruction-memory read channel between the fetch stage (master) and instruction memory (slave).
// Single outstanding request: req/ready handshake for the address, rvalid/rdata for the response.
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, addr, input ready, rvalid, rdata);
    modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one read at a time to instruction memory and presents the
// fetched instruction to IF/ID, honouring downstream stall and EX redirects (stale responses are drained).
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    fetch_stage_if.master   imem,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_p4_out,
    output logic [XLEN-1:0] instr_out,
    output logic [4:0]      rd_out,
    output logic            valid_out
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] hold_buf, hold_buf_n;
    logic [XLEN-1:0] pc_p4;
    logic [XLEN-1:0] redirect_target;

    assign pc_p4           = pc + XLEN'(4);
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            hold_buf <= NOP_INSTR;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            hold_buf <= hold_buf_n;
        end
    end

    // NOTE: every comb output is defaulted first so no path leaves a value unassigned (no latches).
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        hold_buf_n = hold_buf;
        if (redirect) begin
            // Redirect outranks stall; an already-accepted request must be drained before refetching.
            pc_n       = redirect_target;
            hold_buf_n = NOP_INSTR;
            unique case (state)
                S_REQ:   state_n = imem.ready  ? S_DRAIN : S_REQ;
                S_WAIT:  state_n = imem.rvalid ? S_REQ   : S_DRAIN;
                S_HOLD:  state_n = S_REQ;
                S_DRAIN: state_n = imem.rvalid ? S_REQ   : S_DRAIN;
                default: state_n = S_REQ;
            endcase
        end else begin
            unique case (state)
                S_REQ: begin
                    if (imem.ready) state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (imem.rvalid) begin
                        if (stall) begin
                            hold_buf_n = imem.rdata;
                            state_n    = S_HOLD;
                        end else begin
                            pc_n    = pc_p4;
                            state_n = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        pc_n       = pc_p4;
                        hold_buf_n = NOP_INSTR;
                        state_n    = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem.rvalid) state_n = S_REQ;
                end
                default: state_n = S_REQ;
            endcase
        end
    end

    always_comb begin
        imem.req  = (state == S_REQ) && !rst;
        valid_out = 1'b0;
        instr_out = NOP_INSTR;
        if (!redirect) begin
            if (state == S_WAIT && imem.rvalid) begin
                valid_out = 1'b1;
                instr_out = imem.rdata;
            end else if (state == S_HOLD) begin
                valid_out = 1'b1;
                instr_out = hold_buf;
            end
        end
    end

    assign imem.addr = pc;
    assign pc_out    = pc;
    assign pc_p4_out = pc_p4;
    assign rd_out    = instr_out[11:7];

    rvalid_in_window: assert property (@(posedge clk) disable iff (rst)
        imem.rvalid |-> (state == S_WAIT || state == S_DRAIN));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected fetches/addresses into queues,
// negedge monitors pop and compare whenever IF/ID would capture or memory accepts a request.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_p4;
        logic [31:0] instr;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc_out, pc_p4_out, instr_out;
    logic [4:0]  rd_out;
    logic        valid_out;

    int checks = 0;
    int errors = 0;

    fetch_t      exp_q[$];
    logic [31:0] addr_q[$];

    fetch_stage_if #(.XLEN(32)) imem ();

    fetch_stage #(
        .XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem(imem), .pc_out(pc_out), .pc_p4_out(pc_p4_out), .instr_out(instr_out),
        .rd_out(rd_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Capture monitor: IF/ID takes the instruction when valid_out & !stall.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_out && !stall) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(valid_out), 32'h0);
                end else begin
                    fetch_t e;
                    e = exp_q.pop_front();
                    check("cap_pc", pc_out, e.pc);
                    check("cap_pc_p4", pc_p4_out, e.pc_p4);
                    check("cap_instr", instr_out, e.instr);
                    check("cap_rd", 32'(rd_out), 32'(e.instr[11:7]));
                end
            end else if (!valid_out) begin
                check("idle_instr_nop", instr_out, NOP);
            end
            if (imem.req && imem.ready) begin
                if (addr_q.size() == 0) check("unexpected_req", imem.addr, 32'hxxxx_xxxx);
                else check("req_addr", imem.addr, addr_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered and left just after a posedge with the FSM in S_REQ.
    task automatic fetch(input logic [31:0] a, input logic [31:0] p4, input logic [31:0] d, input int ns);
        imem.ready = 1'b1;
        addr_q.push_back(a);
        step();
        imem.ready = 1'b0;
        stall      = (ns > 0);
        step();
        imem.rvalid = 1'b1;
        imem.rdata  = d;
        exp_q.push_back('{pc: a, pc_p4: p4, instr: d});
        if (ns > 0) begin
            for (int i = 0; i < ns; i++) begin
                @(negedge clk);
                check("stall_valid", 32'(valid_out), 32'h1);
                check("stall_instr", instr_out, d);
                check("stall_pc", pc_out, a);
                step();
                imem.rvalid = 1'b0;
            end
            stall = 1'b0;
        end
        step();
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
    endtask

    task automatic redirect_in_req(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        @(negedge clk);
        check("redir_req_valid", 32'(valid_out), 32'h0);
        step();
        redirect = 1'b0;
    endtask

    initial begin
        imem.ready  = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = '0;
        #1 rst = 1'b1;
        #2;
        check("rst_req", 32'(imem.req), 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_instr", instr_out, NOP);
        check("rst_rd", 32'(rd_out), 32'h0);
        check("rst_pc", pc_out, 32'h0);
        check("rst_pc_p4", pc_p4_out, 32'h4);
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("req_after_rst", 32'(imem.req), 32'h1);
        check("addr_after_rst", imem.addr, 32'h0);
        step();

        // T1: straight-line fetches
        fetch(32'h0, 32'h4, 32'h0010_0093, 0);
        fetch(32'h4, 32'h8, 32'h0020_0113, 0);

        // T3: redirect while waiting; late response for 0x8 must be dropped
        imem.ready = 1'b1;
        addr_q.push_back(32'h8);
        step();
        imem.ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        check("t3_valid_redir", 32'(valid_out), 32'h0);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("t3_drain_req", 32'(imem.req), 32'h0);
        step();
        imem.rvalid = 1'b1;
        imem.rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t3_drain_valid", 32'(valid_out), 32'h0);
        step();
        imem.rvalid = 1'b0;
        fetch(32'h200, 32'h204, 32'h0030_0193, 0);

        // T2: redirect in S_REQ without ready, then a 3-cycle stall on the response
        redirect_in_req(32'h10);
        fetch(32'h10, 32'h14, 32'h0040_0213, 3);
        fetch(32'h14, 32'h18, 32'h0050_0293, 0);

        // T4: redirect to an unaligned target coinciding with rvalid
        imem.ready = 1'b1;
        addr_q.push_back(32'h18);
        step();
        imem.ready = 1'b0;
        step();
        imem.rvalid = 1'b1;
        imem.rdata  = 32'hBAD0_0F93;
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        @(negedge clk);
        check("t4_valid", 32'(valid_out), 32'h0);
        step();
        imem.rvalid = 1'b0;
        redirect    = 1'b0;
        @(negedge clk);
        check("t4_pc", pc_out, 32'h100);
        step();
        fetch(32'h100, 32'h104, 32'h0060_0313, 0);

        // T5: PC wrap-around
        redirect_in_req(32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h0, 32'h0070_0393, 0);
        fetch(32'h0, 32'h4, 32'h0080_0413, 0);

        // T6: reset asserted while holding a stalled instruction
        imem.ready = 1'b1;
        addr_q.push_back(32'h4);
        step();
        imem.ready = 1'b0;
        stall      = 1'b1;
        step();
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h0090_0493;
        @(negedge clk);
        check("t6_pre_valid", 32'(valid_out), 32'h1);
        step();
        imem.rvalid = 1'b0;
        @(negedge clk);
        check("t6_hold_instr", instr_out, 32'h0090_0493);
        step();
        rst = 1'b1;
        #1;
        check("t6_valid", 32'(valid_out), 32'h0);
        check("t6_instr", instr_out, NOP);
        check("t6_pc", pc_out, 32'h0);
        check("t6_req", 32'(imem.req), 32'h0);
        stall = 1'b0;
        step();
        rst = 1'b0;
        step();
        fetch(32'h0, 32'h4, 32'h00A0_0513, 0);

        step();
        check("exp_q_empty", 32'(exp_q.size()), 32'h0);
        check("addr_q_empty", 32'(addr_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
